uart_line_echo: RTL and testbench

UART_LINE_ECHO -- requirements
Module: uart_line_echo

---
 rtl/uart_line_echo.sv | 167 ++++++++++++++++
 tb/tb_uart_line_echo.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_echo.sv
// -----------------------------------------------------------------------------
// uart_line_echo
//
// Collects bytes from an upstream UART receiver into a line buffer until a
// terminator byte (TERM_A or TERM_B) arrives, then echoes the stored line to
// a downstream UART transmitter followed by CR LF. Terminators are never
// stored, and a terminator arriving on an empty line is ignored, so a CR LF
// pair produces one echo. Bytes arriving while the buffer is full are
// dropped, and each dropped byte raises a one-cycle overflow pulse.
//
// Ports
//   clk            clock, all state updates on rising edge
//   rst            asynchronous active-high reset
//   rx_data        received byte from the UART receiver
//   rx_data_valid  rx_data is valid
//   rx_data_ready  block accepts a byte this cycle (high while collecting)
//   tx_data        byte offered to the UART transmitter
//   tx_data_valid  tx_data is valid
//   tx_data_ready  transmitter accepts tx_data this cycle
//   line_len       stored length of the line being echoed (0 while collecting)
//   overflow       one-cycle pulse per byte dropped because the buffer is full
// -----------------------------------------------------------------------------
module uart_line_echo #(
    parameter int          DEPTH  = 64,
    parameter logic [7:0]  TERM_A = 8'h0d,
    parameter logic [7:0]  TERM_B = 8'h0a
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic       rx_data_ready,
    output logic [7:0] tx_data,
    output logic       tx_data_valid,
    input  logic       tx_data_ready,
    output logic [8:0] line_len,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        COLLECT,
        SEND_BODY,
        SEND_CR,
        SEND_LF
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic [AW-1:0]   rd_idx_q;
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;
    logic            rx_ready_q;
    logic            overflow_q;
    logic [8:0]      line_len_q;

    // Line storage; deliberately not reset, only the bookkeeping is.
    logic [7:0]      buf_mem [DEPTH];

    logic            rx_fire;
    logic            tx_fire;
    logic            is_term;
    logic            buf_full;
    logic            wr_en;
    logic            last_body;
    logic [AW-1:0]   rd_idx_d;

    assign rx_fire   = rx_data_valid && rx_ready_q && (state_q == COLLECT);
    assign tx_fire   = tx_valid_q && tx_data_ready;
    assign is_term   = (rx_data == TERM_A) || (rx_data == TERM_B);
    assign buf_full  = (count_q == FULL_COUNT);
    assign wr_en     = rx_fire && !is_term && !buf_full;
    assign rd_idx_d  = rd_idx_q + AW'(1);
    // Index of the byte currently offered is the last one of the line.
    assign last_body = ((9'(rd_idx_q) + 9'd1) == line_len_q);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[count_q[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT;
            count_q    <= '0;
            rd_idx_q   <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            overflow_q <= 1'b0;
            line_len_q <= 9'd0;
        end else begin
            overflow_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (rx_fire) begin
                        if (is_term) begin
                            // Empty-line terminators are absorbed silently.
                            if (count_q != '0) begin
                                state_q    <= SEND_BODY;
                                line_len_q <= 9'(count_q);
                                rd_idx_q   <= '0;
                                // First byte is loaded now so it is valid on
                                // the first cycle of SEND_BODY.
                                tx_data_q  <= buf_mem[0];
                                tx_valid_q <= 1'b1;
                                rx_ready_q <= 1'b0;
                            end
                        end else if (buf_full) begin
                            overflow_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
                    end
                end

                SEND_BODY: begin
                    if (tx_fire) begin
                        if (last_body) begin
                            state_q   <= SEND_CR;
                            tx_data_q <= 8'h0d;
                        end else begin
                            rd_idx_q  <= rd_idx_d;
                            tx_data_q <= buf_mem[rd_idx_d];
                        end
                    end
                end

                SEND_CR: begin
                    if (tx_fire) begin
                        state_q   <= SEND_LF;
                        tx_data_q <= 8'h0a;
                    end
                end

                SEND_LF: begin
                    if (tx_fire) begin
                        state_q    <= COLLECT;
                        count_q    <= '0;
                        rd_idx_q   <= '0;
                        line_len_q <= 9'd0;
                        tx_data_q  <= 8'h00;
                        tx_valid_q <= 1'b0;
                        rx_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q    <= COLLECT;
                    tx_valid_q <= 1'b0;
                    rx_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign rx_data_ready = rx_ready_q;
    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign line_len      = line_len_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_uart_line_echo.sv
module tb_uart_line_echo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic [8:0] line_len;
    logic       overflow;

    uart_line_echo #(
        .DEPTH  (DEPTH),
        .TERM_A (8'h0d),
        .TERM_B (8'h0a)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .line_len      (line_len),
        .overflow      (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ovf_cnt = 0;
    int tx_mode = 1;   // 0: ready low, 1: ready high, 2: random

    // Behavioural model: bytes of the line being collected, bytes still to emit.
    logic [7:0] m_line [$];
    logic [7:0] m_out  [$];
    int         m_len = 0;
    bit         m_ovf = 1'b0;

    // Log of transmitted bytes for the literal checks.
    logic [7:0] tx_log [$];
    int         tx_cyc [$];
    int         tx_len [$];
    logic [7:0] exp_q  [$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transmit-side ready driver.
    initial begin
        tx_data_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                0: tx_data_ready = 1'b0;
                1: tx_data_ready = 1'b1;
                default: tx_data_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Per-cycle compare against the model, then advance the model with the
    // inputs that the DUT will sample at the next rising edge.
    always @(negedge clk) begin
        bit busy;
        if (rst) begin
            chk("rst_tx_valid", tx_data_valid, 0);
            chk("rst_tx_data", tx_data, 0);
            chk("rst_line_len", line_len, 0);
            chk("rst_overflow", overflow, 0);
            m_line.delete();
            m_out.delete();
            m_len = 0;
            m_ovf = 1'b0;
        end else begin
            busy = (m_out.size() > 0);
            chk("rx_ready", rx_data_ready, busy ? 0 : 1);
            chk("tx_valid", tx_data_valid, busy ? 1 : 0);
            if (busy) chk("tx_data", tx_data, m_out[0]);
            chk("line_len", line_len, busy ? m_len : 0);
            chk("overflow", overflow, m_ovf);
            if (overflow) ovf_cnt++;
            if (tx_data_valid && tx_data_ready) begin
                tx_log.push_back(tx_data);
                tx_cyc.push_back(cyc);
                tx_len.push_back(int'(line_len));
            end
            m_ovf = 1'b0;
            if (busy) begin
                if (tx_data_ready) begin
                    void'(m_out.pop_front());
                    if (m_out.size() == 0) begin
                        $display("echo line complete: len=%0d at cycle %0d", m_len, cyc);
                        m_len = 0;
                    end
                end
            end else if (rx_data_valid) begin
                if (rx_data == 8'h0d || rx_data == 8'h0a) begin
                    if (m_line.size() > 0) begin
                        m_out = m_line;
                        m_out.push_back(8'h0d);
                        m_out.push_back(8'h0a);
                        m_len = m_line.size();
                        m_line.delete();
                    end
                end else if (m_line.size() < DEPTH) begin
                    m_line.push_back(rx_data);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 right after the accept edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data = b;
        rx_data_valid = 1'b1;
        @(negedge clk);
        while (!rx_data_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) chk("rx_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic rx_stop();
        rx_data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(m_out.size() == 0 && !tx_data_valid) && n < 500);
        if (n >= 500) chk("wait_idle_timeout", 0, 1);
    endtask

    task automatic clear_log();
        tx_log.delete();
        tx_cyc.delete();
        tx_len.delete();
        ovf_cnt = 0;
    endtask

    task automatic chk_log(input string name);
        chk({name, "_count"}, tx_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
            chk({name, "_byte"}, tx_log[i], exp_q[i]);
        end
    endtask

    initial begin
        int n;
        int len;
        logic [7:0] b;

        rst = 1'b1;
        rx_data = 8'h00;
        rx_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // "AB" CR with ready held high: four back-to-back bytes.
        clear_log();
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h0d);
        rx_stop();
        wait_idle();
        exp_q = '{8'h41, 8'h42, 8'h0d, 8'h0a};
        chk_log("ab_echo");
        chk("ab_consecutive", (tx_cyc.size() >= 4) ? tx_cyc[3] - tx_cyc[0] : -1, 3);
        chk("ab_line_len", (tx_len.size() >= 1) ? tx_len[0] : -1, 2);
        chk("ab_overflow", ovf_cnt, 0);
        $display("line AB done: %0d bytes echoed", tx_log.size());

        // Lone terminators produce nothing.
        clear_log();
        send_byte(8'h0d); send_byte(8'h0a); send_byte(8'h0d);
        rx_stop();
        idle(5);
        chk("empty_no_echo", tx_log.size(), 0);
        chk("empty_ready", rx_data_ready, 1);
        $display("empty lines done");

        // Overflow: "ABCDEF" LF into a 4-byte buffer.
        clear_log();
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
        send_byte(8'h44); send_byte(8'h45); send_byte(8'h46);
        send_byte(8'h0a);
        rx_stop();
        wait_idle();
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0d, 8'h0a};
        chk_log("ovf_echo");
        chk("ovf_pulses", ovf_cnt, 2);
        chk("ovf_line_len", (tx_len.size() >= 1) ? tx_len[0] : -1, 4);
        $display("overflow line done: %0d pulses", ovf_cnt);

        // Back-pressure: "XY" CR, ready low for 10 cycles.
        tx_mode = 0;
        clear_log();
        send_byte(8'h58); send_byte(8'h59); send_byte(8'h0d);
        rx_stop();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", tx_data_valid, 1);
            chk("hold_data", tx_data, 8'h58);
            chk("hold_rx_ready", rx_data_ready, 0);
        end
        tx_mode = 1;
        wait_idle();
        exp_q = '{8'h58, 8'h59, 8'h0d, 8'h0a};
        chk_log("hold_echo");
        $display("back-pressure line done");

        // Reset mid-echo of "HELLO" (buffer keeps "HELL").
        clear_log();
        send_byte(8'h48); send_byte(8'h45); send_byte(8'h4c);
        send_byte(8'h4c); send_byte(8'h4f); send_byte(8'h0d);
        rx_stop();
        n = 0;
        while (tx_log.size() < 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("rst_wait_timeout", 0, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", tx_data_valid, 0);
        idle(2);
        rst = 1'b0;
        idle(5);
        chk("rst_abandon", tx_log.size(), 2);
        send_byte(8'h5a); send_byte(8'h0d);
        rx_stop();
        wait_idle();
        exp_q = '{8'h48, 8'h45, 8'h5a, 8'h0d, 8'h0a};
        chk_log("rst_echo");
        $display("reset mid-echo done");

        // Valid held high across two lines with a CR LF pair.
        clear_log();
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h0d);
        send_byte(8'h0a); send_byte(8'h43); send_byte(8'h0d);
        rx_stop();
        wait_idle();
        exp_q = '{8'h41, 8'h42, 8'h0d, 8'h0a, 8'h43, 8'h0d, 8'h0a};
        chk_log("stream_echo");
        $display("streamed lines done");

        // Randomised traffic against the model.
        tx_mode = 2;
        for (int l = 0; l < 150; l++) begin
            len = $urandom_range(0, 6);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 7) == 0)
                    b = ($urandom_range(0, 1) == 0) ? 8'h0d : 8'h0a;
                else
                    b = 8'($urandom_range(32, 126));
                send_byte(b);
                if ($urandom_range(0, 3) == 0) begin
                    rx_stop();
                    idle($urandom_range(1, 2));
                end
            end
            send_byte(($urandom_range(0, 1) == 0) ? 8'h0d : 8'h0a);
            if ($urandom_range(0, 2) == 0) begin
                rx_stop();
                idle($urandom_range(1, 3));
            end
        end
        rx_stop();
        tx_mode = 1;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
